// File: rtl/ram_responder.sv
// ram_responder
//   Synchronous single-port RAM at the memory end of the wr_en/rd_en/address/
//   data_in/data_out pin protocol. After every reset a built-in init FSM
//   clears the whole array, so a read never returns X. Reads are pipelined
//   (RD_LAT = 1 or 2) and flagged with rd_valid.
//
// Ports
//   clk          in   1       single clock, all logic on posedge
//   rst          in   1       synchronous, active-low reset
//   wr_en        in   1       write strobe
//   rd_en        in   1       read strobe
//   address      in   ADDR_W  word address
//   data_in      in   WIDTH   write data
//   data_out     out  WIDTH   read data, holds the last read value
//   rd_valid     out  1       1-cycle pulse with each read result
//   busy         out  1       high while the array is being cleared
//   err_drop     out  1       1-cycle pulse: access discarded while busy
//   addr_err     out  1       1-cycle pulse: access with address >= DEPTH
//   inj_par_err  in   1       (RAM_PARITY_EN only) invert stored parity on write
//   parity_err   out  1       (RAM_PARITY_EN only) parity mismatch, with rd_valid
//
// Configuration
//   RAM_PARITY_EN : when defined, each word carries an even-parity bit.
//   WIDTH / DEPTH default to `WIDTH / `DEPTH, falling back to 8 / 12.
//   DEPTH must be at least 2.

`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef DEPTH
`define DEPTH 12
`endif

module ram_responder #(
  parameter int WIDTH  = `WIDTH,
  parameter int DEPTH  = `DEPTH,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  data_in,
`ifdef RAM_PARITY_EN
  input  logic              inj_par_err,
  output logic              parity_err,
`endif
  output logic [WIDTH-1:0]  data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              err_drop,
  output logic              addr_err
);

  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  logic                ready;
  logic                addr_ok;
  logic                rd_fire;
  logic [WIDTH-1:0]    rd_word;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [WIDTH-1:0]    mem_wdata;

  logic                s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]    s1_data_q, s1_data_d;
  logic                err_drop_q, err_drop_d;
  logic                addr_err_q, addr_err_d;

`ifdef RAM_PARITY_EN
  logic                par_q [DEPTH];
  logic                mem_wpar;
  logic                s1_perr_q, s1_perr_d;
`endif

  assign ready   = (state_q == S_READY);
  assign busy    = (state_q == S_INIT);
  assign addr_ok = ({1'b0, address} < DEPTH_W);
  assign rd_fire = ready && rd_en;
  assign rd_word = addr_ok ? mem_q[address] : '0;

  // Init sequencer: one word cleared per cycle, handing over to READY
  // once the last address has been written.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == S_INIT) begin
      init_ptr_d = init_ptr_q + ADDR_W'(1);
      if (init_ptr_q == LAST_ADDR) begin
        state_d    = S_READY;
        init_ptr_d = '0;
      end
    end
  end

  // Single write port shared by the clear sequence and user writes;
  // out-of-range user writes never enable it.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = data_in;
    if (!ready) begin
      mem_we    = 1'b1;
      mem_waddr = init_ptr_q;
      mem_wdata = '0;
    end else if (wr_en && addr_ok) begin
      mem_we = 1'b1;
    end
  end

`ifdef RAM_PARITY_EN
  assign mem_wpar = ready ? ((^data_in) ^ inj_par_err) : 1'b0;
`endif

  // First read stage; data is captured from the pre-write array contents,
  // which gives read-first behaviour for a same-address read/write.
  always_comb begin
    s1_valid_d = rd_fire;
    s1_data_d  = rd_fire ? rd_word : s1_data_q;
    err_drop_d = busy && (wr_en || rd_en);
    addr_err_d = ready && (wr_en || rd_en) && !addr_ok;
`ifdef RAM_PARITY_EN
    s1_perr_d  = rd_fire && addr_ok && ((^mem_q[address]) != par_q[address]);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_INIT;
      init_ptr_q <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      err_drop_q <= 1'b0;
      addr_err_q <= 1'b0;
`ifdef RAM_PARITY_EN
      s1_perr_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      err_drop_q <= err_drop_d;
      addr_err_q <= addr_err_d;
`ifdef RAM_PARITY_EN
      s1_perr_q  <= s1_perr_d;
`endif
    end
  end

  // Storage array has no reset; the init sequence clears it after reset.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
`ifdef RAM_PARITY_EN
      par_q[mem_waddr] <= mem_wpar;
`endif
    end
  end

  assign err_drop = err_drop_q;
  assign addr_err = addr_err_q;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic             s2_valid_q, s2_valid_d;
      logic [WIDTH-1:0] s2_data_q, s2_data_d;
`ifdef RAM_PARITY_EN
      logic             s2_perr_q, s2_perr_d;
`endif

      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
`ifdef RAM_PARITY_EN
        s2_perr_d  = s1_perr_q;
`endif
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
`ifdef RAM_PARITY_EN
          s2_perr_q  <= 1'b0;
`endif
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_data_q  <= s2_data_d;
`ifdef RAM_PARITY_EN
          s2_perr_q  <= s2_perr_d;
`endif
        end
      end

      assign rd_valid = s2_valid_q;
      assign data_out = s2_data_q;
`ifdef RAM_PARITY_EN
      assign parity_err = s2_perr_q;
`endif
    end else begin : g_lat1
      assign rd_valid = s1_valid_q;
      assign data_out = s1_data_q;
`ifdef RAM_PARITY_EN
      assign parity_err = s1_perr_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder (WIDTH=8, DEPTH=12, RD_LAT=1).
// Directed steps followed by randomized traffic; expected values come from
// a behavioural memory model kept in this file.

module tb_ram_responder;

  localparam int WIDTH = 8;
  localparam int DEPTH = 12;

  logic             clk;
  logic             rst;
  logic             wrEn;
  logic             rdEn;
  logic [3:0]       address;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             rdValid;
  logic             busy;
  logic             errDrop;
  logic             addrErr;
  logic             injParErr;
`ifdef RAM_PARITY_EN
  logic             parityErr;
`endif

  ram_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wrEn),
    .rd_en      (rdEn),
    .address    (address),
    .data_in    (dataIn),
`ifdef RAM_PARITY_EN
    .inj_par_err(injParErr),
    .parity_err (parityErr),
`endif
    .data_out   (dataOut),
    .rd_valid   (rdValid),
    .busy       (busy),
    .err_drop   (errDrop),
    .addr_err   (addrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int             initCount = 0;
  logic [7:0]     refMem [DEPTH];
  bit             refBad [DEPTH];
  logic           expValid, expErrDrop, expAddrErr, expBusy, expPerr;
  logic [7:0]     expData;

  task automatic check(input string name, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".busy"},     {7'd0, busy},    {7'd0, expBusy});
    check({tag, ".rd_valid"}, {7'd0, rdValid}, {7'd0, expValid});
    check({tag, ".data_out"}, dataOut,         expData);
    check({tag, ".err_drop"}, {7'd0, errDrop}, {7'd0, expErrDrop});
    check({tag, ".addr_err"}, {7'd0, addrErr}, {7'd0, expAddrErr});
`ifdef RAM_PARITY_EN
    check({tag, ".parity_err"}, {7'd0, parityErr}, {7'd0, expPerr});
`endif
  endtask

  // Drive one cycle of inputs, advance the model by one edge, compare.
  task automatic applyStimulus(input string tag, input bit rstIn, input bit w, input bit r,
                               input logic [3:0] a, input logic [7:0] d, input bit inj);
    bit inRange;
    rst       = rstIn;
    wrEn      = w;
    rdEn      = r;
    address   = a;
    dataIn    = d;
    injParErr = inj;
    @(posedge clk);
    #1;
    expPerr = 1'b0;
    if (!rstIn) begin
      initCount  = 0;
      expValid   = 1'b0;
      expData    = 8'h00;
      expErrDrop = 1'b0;
      expAddrErr = 1'b0;
    end else if (initCount < DEPTH) begin
      initCount++;
      expValid   = 1'b0;
      expErrDrop = w | r;
      expAddrErr = 1'b0;
      if (initCount == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) begin
          refMem[i] = 8'h00;
          refBad[i] = 1'b0;
        end
      end
    end else begin
      inRange    = (int'(a) < DEPTH);
      expErrDrop = 1'b0;
      expAddrErr = (w | r) && !inRange;
      expValid   = r;
      if (r) begin
        expData = inRange ? refMem[a] : 8'h00;
        expPerr = inRange && refBad[a];
      end
      if (w && inRange) begin
        refMem[a] = d;
        refBad[a] = inj;
      end
    end
    expBusy = (initCount < DEPTH);
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b0; wrEn = 1'b0; rdEn = 1'b0; address = '0; dataIn = '0; injParErr = 1'b0;

    // Reset for two cycles, then let the array clear; one write during
    // the clear must be dropped.
    applyStimulus("reset0", 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    applyStimulus("reset1", 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i == 3) applyStimulus("initWrite", 1'b1, 1'b1, 1'b0, 4'd2, 8'h77, 1'b0);
      else        applyStimulus("init",      1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    end

    for (int a = 0; a < DEPTH; a++)
      applyStimulus("readZero", 1'b1, 1'b0, 1'b1, 4'(a), 8'h00, 1'b0);

    applyStimulus("writeA5",  1'b1, 1'b1, 1'b0, 4'd3, 8'hA5, 1'b0);
    applyStimulus("readA5",   1'b1, 1'b0, 1'b1, 4'd3, 8'h00, 1'b0);
    applyStimulus("idle",     1'b1, 1'b0, 1'b0, 4'd3, 8'h00, 1'b0);

    applyStimulus("write11",  1'b1, 1'b1, 1'b0, 4'd5, 8'h11, 1'b0);
    applyStimulus("rdFirst",  1'b1, 1'b1, 1'b1, 4'd5, 8'h3C, 1'b0);
    applyStimulus("read3C",   1'b1, 1'b0, 1'b1, 4'd5, 8'h00, 1'b0);
    applyStimulus("bothDiff", 1'b1, 1'b1, 1'b1, 4'd6, 8'h42, 1'b0);

    applyStimulus("readOob",  1'b1, 1'b0, 1'b1, 4'd12, 8'h00, 1'b0);
    applyStimulus("writeOob", 1'b1, 1'b1, 1'b0, 4'd14, 8'h99, 1'b0);
    applyStimulus("readOob15",1'b1, 1'b0, 1'b1, 4'd15, 8'h00, 1'b0);
    for (int a = 0; a < 4; a++)
      applyStimulus("fill", 1'b1, 1'b1, 1'b0, 4'(a), 8'(a + 1), 1'b0);
    for (int a = 0; a < 4; a++)
      applyStimulus("b2bRead", 1'b1, 1'b0, 1'b1, 4'(a), 8'h00, 1'b0);
    for (int a = 0; a < DEPTH; a++)
      applyStimulus("scan", 1'b1, 1'b0, 1'b1, 4'(a), 8'h00, 1'b0);

`ifdef RAM_PARITY_EN
    applyStimulus("parInj",   1'b1, 1'b1, 1'b0, 4'd7, 8'hFF, 1'b1);
    applyStimulus("parRead",  1'b1, 1'b0, 1'b1, 4'd7, 8'h00, 1'b0);
    applyStimulus("parClean", 1'b1, 1'b1, 1'b0, 4'd7, 8'hFF, 1'b0);
    applyStimulus("parRead2", 1'b1, 1'b0, 1'b1, 4'd7, 8'h00, 1'b0);
`endif

    // Reset right after a read: output must clear, then clear restarts.
    applyStimulus("preRst",   1'b1, 1'b0, 1'b1, 4'd3, 8'h00, 1'b0);
    applyStimulus("rstFlush", 1'b0, 1'b0, 1'b1, 4'd3, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus("reinit", 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    applyStimulus("rstMidInit", 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus("reinit2", 1'b1, 1'b0, 1'b1, 4'd1, 8'h00, 1'b0);
    applyStimulus("readCleared", 1'b1, 1'b0, 1'b1, 4'd3, 8'h00, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(0, 63) != 0), 1'($urandom), 1'($urandom),
                    4'($urandom_range(0, 15)), 8'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
